// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Owns the single register-file write port and arbitrates between two
// writers:
//   P : the pipeline writeback stage (no backpressure, highest priority)
//   M : a multi-cycle unit using a valid/ready handshake
// A 32-entry busy scoreboard tracks registers with an outstanding M
// operation so the decode stage can detect RAW hazards on ra/rb.
//
// Optional feature (macro RF_WB_STARVE_EN):
//   When defined, a 4-bit starvation counter counts consecutive cycles in
//   which M is valid but not granted. When the count reaches STARVE_LIMIT
//   the pipeline is frozen for exactly one cycle (p_stall) and M is granted
//   in that cycle. When undefined, p_stall is tied low and M may wait
//   indefinitely behind a busy pipeline.
//
// Parameters:
//   STARVE_LIMIT  stalled M cycles before the pipeline is frozen (1..15)
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   p_we, p_rw, p_w           pipeline writeback request
//   m_valid, m_rw, m_w        M write request (held until m_ready)
//   m_ready                   combinational grant to M
//   m_issue, m_issue_rd       M operation issued; marks m_issue_rd busy
//   ra, rb                    read addresses to hazard-check
//   busy_a, busy_b            scoreboard bits of ra / rb
//   p_stall                   registered one-cycle pipeline freeze
//   rf_we, rf_rw, rf_w        registered register-file write port
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_we,
  input  logic [4:0]  p_rw,
  input  logic [31:0] p_w,
  input  logic        m_valid,
  input  logic [4:0]  m_rw,
  input  logic [31:0] m_w,
  output logic        m_ready,
  input  logic        m_issue,
  input  logic [4:0]  m_issue_rd,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        busy_a,
  output logic        busy_b,
  output logic        p_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_w
);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("rf_wb_arbiter: STARVE_LIMIT must be within 1..15");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic p_accept;
  logic m_grant;

  // M may go when P is idle, when P is frozen, or when M's write is a
  // discard (destination 0) and therefore does not need the write port.
  assign m_ready  = m_valid & (~p_we | p_stall | (m_rw == 5'd0));
  assign p_accept = p_we & ~p_stall;
  assign m_grant  = m_valid & m_ready;

  // -------------------------------------------------------------------------
  // Registered write port (one-cycle latency from acceptance)
  // -------------------------------------------------------------------------
  logic        rf_we_reg,  rf_we_next;
  logic [4:0]  rf_rw_reg,  rf_rw_next;
  logic [31:0] rf_w_reg,   rf_w_next;

  always_comb begin
    rf_we_next = 1'b0;
    rf_rw_next = rf_rw_reg;
    rf_w_next  = rf_w_reg;
    if (p_accept) begin
      rf_we_next = (p_rw != 5'd0);
      rf_rw_next = p_rw;
      rf_w_next  = p_w;
    end else if (m_grant) begin
      rf_we_next = (m_rw != 5'd0);
      rf_rw_next = m_rw;
      rf_w_next  = m_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_reg <= 1'b0;
      rf_rw_reg <= 5'd0;
      rf_w_reg  <= 32'd0;
    end else begin
      rf_we_reg <= rf_we_next;
      rf_rw_reg <= rf_rw_next;
      rf_w_reg  <= rf_w_next;
    end
  end

  assign rf_we = rf_we_reg;
  assign rf_rw = rf_rw_reg;
  assign rf_w  = rf_w_reg;

  // -------------------------------------------------------------------------
  // Scoreboard clear pipeline
  // An accepted M write clears its busy bit at the end of the cycle in which
  // it is presented on rf_we, so the register reads busy until the register
  // file actually holds the value. The grant is therefore delayed one stage.
  // -------------------------------------------------------------------------
  logic       clr_valid_reg, clr_valid_next;
  logic [4:0] clr_rd_reg,    clr_rd_next;

  always_comb begin
    clr_valid_next = m_grant & (m_rw != 5'd0);
    clr_rd_next    = m_rw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_valid_reg <= 1'b0;
      clr_rd_reg    <= 5'd0;
    end else begin
      clr_valid_reg <= clr_valid_next;
      clr_rd_reg    <= clr_rd_next;
    end
  end

  // -------------------------------------------------------------------------
  // Busy scoreboard: register 0 has no storage and always reads not-busy.
  // -------------------------------------------------------------------------
  logic [31:1] busy_reg;
  logic [31:0] busy_vec;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi = gi + 1) begin : g_sb
      logic set_bit;
      logic clr_bit;

      assign set_bit = m_issue & (m_issue_rd == 5'(gi));
      assign clr_bit = clr_valid_reg & (clr_rd_reg == 5'(gi));

      // Set has priority so a re-issue in the clearing cycle keeps the bit.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          busy_reg[gi] <= 1'b0;
        end else begin
          busy_reg[gi] <= set_bit | (busy_reg[gi] & ~clr_bit);
        end
      end
    end
  endgenerate

  assign busy_vec = {busy_reg, 1'b0};
  assign busy_a   = busy_vec[ra];
  assign busy_b   = busy_vec[rb];

  // -------------------------------------------------------------------------
  // Starvation guard
  // -------------------------------------------------------------------------
`ifdef RF_WB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       p_stall_reg,    p_stall_next;

  // The freeze is scheduled on the edge where the count would reach the
  // limit, so the stall cycle immediately follows the last stalled cycle.
  always_comb begin
    starve_cnt_next = 4'd0;
    p_stall_next    = 1'b0;
    if (m_valid && !m_ready) begin
      if (starve_cnt_reg + 4'd1 == LIMIT) begin
        p_stall_next = 1'b1;
      end else begin
        starve_cnt_next = starve_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= 4'd0;
      p_stall_reg    <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      p_stall_reg    <= p_stall_next;
    end
  end

  assign p_stall = p_stall_reg;
`else
  assign p_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Scoreboard-style bench: the stimulus process predicts each register-file
// write from a behavioural model and queues it with the cycle in which it
// must appear; an independent monitor compares the write port every cycle.
// Combinational outputs (m_ready, busy_a/b) and p_stall are compared against
// the model each cycle. Directed sequences cover the documented scenarios,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
  localparam int SL = 4;

  logic        clk;
  logic        reset_n;
  logic        p_we;
  logic [4:0]  p_rw;
  logic [31:0] p_w;
  logic        m_valid;
  logic [4:0]  m_rw;
  logic [31:0] m_w;
  logic        m_ready;
  logic        m_issue;
  logic [4:0]  m_issue_rd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        busy_a;
  logic        busy_b;
  logic        p_stall;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_w;

  rf_wb_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .p_we       (p_we),
    .p_rw       (p_rw),
    .p_w        (p_w),
    .m_valid    (m_valid),
    .m_rw       (m_rw),
    .m_w        (m_w),
    .m_ready    (m_ready),
    .m_issue    (m_issue),
    .m_issue_rd (m_issue_rd),
    .ra         (ra),
    .rb         (rb),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .p_stall    (p_stall),
    .rf_we      (rf_we),
    .rf_rw      (rf_rw),
    .rf_w       (rf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  rw;
    logic [31:0] w;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_chk  = 0;

  // Reference model state
  bit mdl_busy[32];
  int mdl_clr_at[32];   // cycle at whose end the busy bit is released
  int mdl_cnt;
  bit mdl_stall;
  bit last_gnt;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cycle_cnt, got, exp);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      mdl_busy[r]   = 1'b0;
      mdl_clr_at[r] = -1;
    end
    mdl_cnt   = 0;
    mdl_stall = 1'b0;
    last_gnt  = 1'b0;
  endfunction

  task automatic set_idle();
    p_we = 0; p_rw = 0; p_w = 0;
    m_valid = 0; m_rw = 0; m_w = 0;
    m_issue = 0; m_issue_rd = 0;
    ra = 0; rb = 0;
  endtask

  // One clock cycle: inputs already driven; compare at the falling edge,
  // advance the model, return 1 time unit after the next rising edge.
  task automatic run_cycle();
    bit  e_ready, p_acc, m_gnt;
    wr_t e;
    @(negedge clk);
    e_ready = m_valid && (!p_we || mdl_stall || m_rw == 5'd0);
    chk("m_ready", m_ready, e_ready);
    chk("p_stall", p_stall, mdl_stall);
    chk("busy_a", busy_a, mdl_busy[ra]);
    chk("busy_b", busy_b, mdl_busy[rb]);
    if (!reset_n) begin
      model_reset();
    end else begin
      p_acc    = p_we && !mdl_stall;
      m_gnt    = m_valid && e_ready;
      last_gnt = m_gnt;
      if (p_acc && p_rw != 5'd0) begin
        e.cyc = cycle_cnt + 1; e.rw = p_rw; e.w = p_w;
        exp_q.push_back(e);
      end
      if (m_gnt && m_rw != 5'd0) begin
        e.cyc = cycle_cnt + 1; e.rw = m_rw; e.w = m_w;
        exp_q.push_back(e);
      end
      for (int r = 0; r < 32; r++) begin
        if (mdl_clr_at[r] == cycle_cnt) begin
          mdl_busy[r]   = 1'b0;
          mdl_clr_at[r] = -1;
        end
      end
      if (m_issue && m_issue_rd != 5'd0) mdl_busy[m_issue_rd] = 1'b1;
      if (m_gnt && m_rw != 5'd0) mdl_clr_at[m_rw] = cycle_cnt + 1;
`ifdef RF_WB_STARVE_EN
      if (m_valid && !e_ready) begin
        mdl_cnt++;
        if (mdl_cnt == SL) begin
          mdl_stall = 1'b1;
          mdl_cnt   = 0;
        end else begin
          mdl_stall = 1'b0;
        end
      end else begin
        mdl_cnt   = 0;
        mdl_stall = 1'b0;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor
  initial begin
    wr_t e;
    bit  exp_we;
    forever begin
      @(negedge clk);
      exp_we = (exp_q.size() != 0) && (exp_q[0].cyc == cycle_cnt);
      chk("rf_we", rf_we, exp_we);
      if (exp_we) begin
        e = exp_q.pop_front();
        chk("rf_rw", rf_rw, e.rw);
        chk("rf_w", rf_w, e.w);
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cycle_cnt) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    set_idle();
    model_reset();

    // Reset state
    run_cycle();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rw", rf_rw, 0);
    chk("rst_rf_w", rf_w, 0);
    run_cycle();
    reset_n = 1'b1;

    // P-only write
    p_we = 1; p_rw = 5; p_w = 32'hDEADBEEF;
    run_cycle();
    set_idle();
    run_cycle();
    run_cycle();

    // P/M conflict: P first, M the next cycle
    p_we = 1; p_rw = 3; p_w = 32'h0000_0033;
    m_valid = 1; m_rw = 7; m_w = 32'h12;
    run_cycle();
    p_we = 0;
    run_cycle();
    set_idle();
    run_cycle();
    run_cycle();

    // Scoreboard set/clear, then with a re-issue in the clearing cycle
    for (int it = 0; it < 2; it++) begin
      set_idle(); ra = 9; rb = 9;
      m_issue = 1; m_issue_rd = 9;
      run_cycle();
      m_issue = 0;
      m_valid = 1; m_rw = 9; m_w = 32'h0000_0099 + it;
      run_cycle();
      m_valid = 0;
      m_issue = (it == 1); m_issue_rd = 9;
      run_cycle();
      m_issue = 0;
      run_cycle();
      run_cycle();
    end
    set_idle(); ra = 9;
    m_valid = 1; m_rw = 9; m_w = 32'h9;
    run_cycle();
    m_valid = 0;
    run_cycle();
    run_cycle();

    // Zero destination on both sides
    set_idle();
    p_we = 1; p_rw = 3; p_w = 32'hCAFE_0003;
    m_valid = 1; m_rw = 0; m_w = 32'h1234;
    m_issue = 1; m_issue_rd = 0;
    run_cycle();
    set_idle();
    run_cycle();
    run_cycle();

    // Starvation: P writes every cycle while M waits
    set_idle();
    m_valid = 1; m_rw = 4; m_w = 32'hA5A5_0004;
    for (int i = 0; i < 10 && m_valid; i++) begin
      p_we = 1; p_rw = 5'($urandom_range(1, 31)); p_w = $urandom;
      run_cycle();
      if (last_gnt) m_valid = 0;
    end
    p_we = 0;
    run_cycle();
    set_idle();
    run_cycle();
    run_cycle();

    // Reset mid-operation with busy bits and a pending write
    set_idle();
    m_issue = 1; m_issue_rd = 12;
    run_cycle();
    m_issue = 0; ra = 12; rb = 12;
    p_we = 1; p_rw = 6; p_w = 32'h6666_6666;
    m_valid = 1; m_rw = 20; m_w = 32'h2020;
    run_cycle();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_rf_we", rf_we, 0);
    chk("rstmid_rf_rw", rf_rw, 0);
    chk("rstmid_rf_w", rf_w, 0);
    chk("rstmid_p_stall", p_stall, 0);
    chk("rstmid_busy_a", busy_a, 0);
    model_reset();
    set_idle(); ra = 12; rb = 20;
    run_cycle();
    run_cycle();
    reset_n = 1'b1;
    run_cycle();
    run_cycle();
    run_cycle();

    // Randomized traffic
    set_idle();
    for (int i = 0; i < 600; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      p_we = ($urandom_range(0, 99) < 55);
      p_rw = 5'($urandom_range(0, 31));
      p_w  = $urandom;
      if (!m_valid || last_gnt) begin
        m_valid = ($urandom_range(0, 99) < 50);
        m_rw = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, narrow ? 7 : 31));
        m_w  = $urandom;
      end
      m_issue    = ($urandom_range(0, 3) == 0);
      m_issue_rd = 5'($urandom_range(0, narrow ? 7 : 31));
      ra = 5'($urandom_range(0, narrow ? 7 : 31));
      rb = 5'($urandom_range(0, 7));
      run_cycle();
    end

    // Drain
    p_we = 0; m_issue = 0;
    for (int i = 0; i < 20; i++) begin
      if (last_gnt) m_valid = 0;
      run_cycle();
    end
    set_idle();
    run_cycle();
    run_cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive stalled M-request cycles before the pipeline is frozen; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 p_we / p_rw / p_w  input  1/5/32  pipeline writeback request; no backpressure.
REQ-005 m_valid / m_rw / m_w  input  1/5/32  multi-cycle unit write request (valid/ready).
REQ-006 m_ready  output  1  combinational grant to the M requester.
REQ-007 m_issue / m_issue_rd  input  1/5  M operation issued; marks m_issue_rd busy.
REQ-008 ra / rb  input  5/5  register-file read addresses to hazard-check.
REQ-009 busy_a / busy_b  output  1/1  combinational; scoreboard bit of ra / rb.
REQ-010 p_stall  output  1  registered; freezes the pipeline for one cycle.
REQ-011 rf_we / rf_rw / rf_w  output  1/5/32  registered register-file write port.

Function
REQ-012 Arbiter shall own the single register-file write port; P has priority over M.
REQ-013 Request accepted in cycle N shall appear on rf_we/rf_rw/rf_w in cycle N+1 (1-cycle latency); rf_we low when no grant.
REQ-014 P accepted whenever p_we=1 and p_stall=0; p_* ignored while p_stall=1.
REQ-015 m_ready = m_valid AND (p_we=0 OR p_stall=1 OR m_rw=0).
REQ-016 M requester shall hold m_valid, m_rw, m_w stable until m_ready=1; transfer occurs on the edge with m_valid=m_ready=1.
REQ-017 Writes with destination 0 (P or M) shall be accepted but produce rf_we=0.
REQ-018 Scoreboard: 32 busy bits; m_issue=1 with m_issue_rd!=0 sets bit m_issue_rd at the edge.
REQ-019 Bit of an accepted M write clears at the edge ending cycle N+1 (the rf_we cycle), so the register reads busy until the RF holds the value.
REQ-020 Simultaneous set and clear of the same bit: set wins.
REQ-021 Bit 0 shall never be set; busy_a/busy_b for address 0 always 0.
REQ-022 busy_a/busy_b reflect current scoreboard only (no same-cycle bypass of m_issue).
REQ-023 Outstanding M operations per register limited to one; m_issue to an already-busy rd is a protocol error, behaviour: bit stays set.

Reset
REQ-024 While reset_n=0: rf_we=0, rf_rw=0, rf_w=0, p_stall=0, all busy bits 0, starvation counter 0; m_ready follows REQ-015 with p_stall=0.
REQ-025 Reset asserted mid-transfer shall discard any pending M request and any registered write; no rf_we pulse after reset release until a new grant.

Configuration
REQ-026 Macro RF_WB_STARVE_EN compiled in: 4-bit counter increments each cycle m_valid=1 AND m_ready=0, clears on M grant or m_valid=0; on reaching STARVE_LIMIT p_stall asserts for exactly the next cycle, counter clears, M granted in that cycle.
REQ-027 RF_WB_STARVE_EN not defined: no counter; p_stall tied 0; M may wait indefinitely.

Verification
REQ-028 P only: p_we=1, p_rw=5, p_w=0xDEADBEEF in cycle N -> rf_we=1, rf_rw=5, rf_w=0xDEADBEEF in N+1, low in N+2.
REQ-029 Conflict: p_we=1 (rw=3) and m_valid=1 (rw=7, w=0x12) same cycle, P idle next -> P written N+1, m_ready=1 in N+1, M written N+2.
REQ-030 Scoreboard: m_issue rd=9; ra=9 -> busy_a=1 through M grant cycle and rf_we cycle; busy_a=0 the cycle after; simultaneous re-issue rd=9 keeps busy_a=1.
REQ-031 Starvation (macro on, STARVE_LIMIT=4): p_we=1 every cycle, m_valid=1 rw=4 -> p_stall=1 exactly one cycle after 4 stalled cycles, M written next cycle, p_we ignored in stall cycle; macro off -> m_ready never asserts.
REQ-032 Zero destination: m_valid=1, m_rw=0 -> m_ready=1 same cycle, rf_we stays 0; m_issue rd=0 leaves all busy 0.
REQ-033 Reset mid-operation: assert reset_n=0 with M pending and busy bits set -> all outputs and busy bits 0 immediately; no write after release.
